// File: rtl/t5_sched.sv
// t5_sched: four-hart round-robin issue scheduler tracking per-hart IDLE/READY/BUSY/WAIT/SLEEP.
// Defining T5_SCHED_WDOG_EN adds a per-hart WAIT watchdog with limit WDOG and a tout pulse.
module t5_sched #(
    parameter logic [7:0] WDOG = 8'd255
) (
    input  logic       sclk,
    input  logic       srst,
    input  logic       sena,
    input  logic [3:0] hrun,
    input  logic       qvld,
    input  logic [1:0] qhart,
    input  logic       qlsu,
    input  logic       qwfi,
    input  logic [3:0] hack,
    input  logic [3:0] irq,
    output logic       fvld,
    output logic [1:0] fhart,
    output logic [3:0] hidle,
    output logic [3:0] tout
);
    localparam int unsigned NHART = 4;
    localparam int unsigned HW    = 2;
    localparam int unsigned CW    = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_BUSY  = 3'd2,
        S_WAIT  = 3'd3,
        S_SLEEP = 3'd4
    } hstate_e;

    hstate_e          st_q [NHART];
    hstate_e          st_d [NHART];
    logic [HW-1:0]    ptr_q, ptr_d;
    logic             fvld_q, fvld_d;
    logic [HW-1:0]    fhart_q, fhart_d;
    logic             pick_vld;
    logic [HW-1:0]    pick_hart;
    logic [NHART-1:0] timeout_c;

    // Round-robin pick: scan ptr+1 .. ptr+4 (wrapping back to ptr itself last).
    always_comb begin
        pick_vld  = 1'b0;
        pick_hart = ptr_q;
        if (sena) begin
            for (int unsigned i = 1; i <= NHART; i++) begin
                if (!pick_vld && (st_q[ptr_q + HW'(i)] == S_READY)) begin
                    pick_vld  = 1'b1;
                    pick_hart = ptr_q + HW'(i);
                end
            end
        end
    end

    // Per-hart next state; earlier branches take priority over later ones.
    always_comb begin
        for (int unsigned h = 0; h < NHART; h++) begin
            st_d[h] = st_q[h];
            if (!hrun[h]) begin
                st_d[h] = S_IDLE;
            end else begin
                case (st_q[h])
                    S_IDLE:  st_d[h] = S_READY;
                    S_READY: if (pick_vld && (pick_hart == HW'(h))) st_d[h] = S_BUSY;
                    S_BUSY: begin
                        if (qvld && (qhart == HW'(h))) begin
                            // A completion arriving with its own report must not be dropped.
                            if (qlsu)      st_d[h] = hack[h] ? S_READY : S_WAIT;
                            else if (qwfi) st_d[h] = S_SLEEP;
                            else           st_d[h] = S_READY;
                        end
                    end
                    S_WAIT:  if (hack[h] || timeout_c[h]) st_d[h] = S_READY;
                    S_SLEEP: if (irq[h]) st_d[h] = S_READY;
                    default: st_d[h] = S_IDLE;
                endcase
            end
        end
        fvld_d  = pick_vld;
        fhart_d = pick_vld ? pick_hart : fhart_q;
        ptr_d   = pick_vld ? pick_hart : ptr_q;
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            for (int unsigned h = 0; h < NHART; h++) st_q[h] <= S_IDLE;
            ptr_q   <= HW'(3);
            fvld_q  <= 1'b0;
            fhart_q <= '0;
        end else begin
            for (int unsigned h = 0; h < NHART; h++) st_q[h] <= st_d[h];
            ptr_q   <= ptr_d;
            fvld_q  <= fvld_d;
            fhart_q <= fhart_d;
        end
    end

`ifdef T5_SCHED_WDOG_EN
    logic [CW-1:0]    cnt_q [NHART];
    logic [CW-1:0]    cnt_d [NHART];
    logic [NHART-1:0] tout_q, tout_d;

    // Timeout fires only if nothing of higher priority (hrun drop, hack) already resolves WAIT.
    always_comb begin
        for (int unsigned h = 0; h < NHART; h++) begin
            timeout_c[h] = (st_q[h] == S_WAIT) && hrun[h] && !hack[h] && (cnt_q[h] == WDOG);
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NHART; h++) begin
            cnt_d[h] = '0;
            if ((st_q[h] == S_WAIT) && (st_d[h] == S_WAIT)) cnt_d[h] = cnt_q[h] + CW'(1);
        end
        tout_d = timeout_c;
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            for (int unsigned h = 0; h < NHART; h++) cnt_q[h] <= '0;
            tout_q <= '0;
        end else begin
            for (int unsigned h = 0; h < NHART; h++) cnt_q[h] <= cnt_d[h];
            tout_q <= tout_d;
        end
    end

    assign tout = tout_q;
`else
    logic unused_wdog;

    assign timeout_c   = '0;
    assign tout        = '0;
    assign unused_wdog = ^WDOG;
`endif

    always_comb begin
        for (int unsigned h = 0; h < NHART; h++) hidle[h] = (st_q[h] == S_IDLE);
    end

    assign fvld  = fvld_q;
    assign fhart = fhart_q;

endmodule

// File: tb/tb_t5_sched.sv
// Scoreboard bench for t5_sched: a rule-level hart model predicts issues, a monitor checks them.
module tb_t5_sched;
    localparam logic [7:0] WDOG_T = 8'd4;
    localparam int M_IDLE = 0, M_READY = 1, M_BUSY = 2, M_WAIT = 3, M_SLEEP = 4;

    logic       sclk = 1'b0;
    logic       srst, sena, qvld, qlsu, qwfi;
    logic [3:0] hrun, hack, irq, hidle, tout;
    logic [1:0] qhart, fhart;
    logic       fvld;

    t5_sched #(.WDOG(WDOG_T)) dut (
        .sclk(sclk), .srst(srst), .sena(sena), .hrun(hrun), .qvld(qvld), .qhart(qhart),
        .qlsu(qlsu), .qwfi(qwfi), .hack(hack), .irq(irq), .fvld(fvld), .fhart(fhart),
        .hidle(hidle), .tout(tout)
    );

    always #5 sclk = ~sclk;

    typedef struct { int cyc; int hart; } exp_t;
    exp_t sb_q[$];
    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference model: hart states, pointer, watchdog counts, and pending next values.
    int ms[4], mcnt[4], mptr, m_pick;
    int p_ms[4], p_cnt[4], p_pick, p_tout;
    int h1 = -1, h2 = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int h = 0; h < 4; h++) begin ms[h] = M_IDLE; mcnt[h] = 0; end
        mptr = 3; m_pick = -1;
    endtask

    // Apply the per-hart priority rules to the currently driven inputs.
    task automatic model_step();
        int pick, tmo, tov, hh;
        exp_t e;
        pick = -1; tov = 0;
        if (sena) begin
            for (int k = 1; k <= 4; k++) begin
                hh = (mptr + k) % 4;
                if (pick < 0 && ms[hh] == M_READY) pick = hh;
            end
        end
        for (int h = 0; h < 4; h++) begin
            tmo = 0;
`ifdef T5_SCHED_WDOG_EN
            tmo = (ms[h] == M_WAIT && hrun[h] && !hack[h] && mcnt[h] == int'(WDOG_T)) ? 1 : 0;
`endif
            if (!hrun[h])                                   p_ms[h] = M_IDLE;
            else if (ms[h] == M_IDLE)                       p_ms[h] = M_READY;
            else if (ms[h] == M_READY && pick == h)         p_ms[h] = M_BUSY;
            else if (ms[h] == M_BUSY && qvld && int'(qhart) == h)
                p_ms[h] = qlsu ? (hack[h] ? M_READY : M_WAIT) : (qwfi ? M_SLEEP : M_READY);
            else if (ms[h] == M_WAIT && (hack[h] || tmo != 0)) p_ms[h] = M_READY;
            else if (ms[h] == M_SLEEP && irq[h])            p_ms[h] = M_READY;
            else                                            p_ms[h] = ms[h];
            p_cnt[h] = (ms[h] == M_WAIT && p_ms[h] == M_WAIT) ? (mcnt[h] + 1) % 256 : 0;
            if (tmo != 0) tov = tov | (1 << h);
        end
        p_pick = pick; p_tout = tov;
        if (pick >= 0) begin
            e.cyc = cyc + 1; e.hart = pick;
            sb_q.push_back(e);
        end
    endtask

    function automatic int model_hidle();
        int r = 0;
        for (int h = 0; h < 4; h++) if (ms[h] == M_IDLE) r = r | (1 << h);
        return r;
    endfunction

    // One clock: drive inputs, predict, advance, check state-derived outputs.
    task automatic cycle(input logic s, input logic [3:0] r, input logic v, input logic [1:0] qh,
                         input logic l, input logic w, input logic [3:0] a, input logic [3:0] i);
        sena = s; hrun = r; qvld = v; qhart = qh; qlsu = l; qwfi = w; hack = a; irq = i;
        model_step();
        @(posedge sclk);
        cyc++;
        for (int h = 0; h < 4; h++) begin ms[h] = p_ms[h]; mcnt[h] = p_cnt[h]; end
        m_pick = p_pick;
        if (p_pick >= 0) mptr = p_pick;
        #1;
        chk("hidle", int'(hidle), model_hidle());
        chk("tout", int'(tout), p_tout);
    endtask

    task automatic reset_pulse();
        #1 srst = 1'b1;
        #1;
        chk("rst_fvld", int'(fvld), 0);
        chk("rst_hidle", int'(hidle), 15);
        chk("rst_fhart", int'(fhart), 0);
        chk("rst_tout", int'(tout), 0);
        sb_q.delete();
        model_reset(); h1 = -1; h2 = -1;
        #1 srst = 1'b0;
    endtask

    // Rotation step: every issue is reported two cycles later.
    task automatic rot_step(input logic [3:0] r, input int lsu_h, input int wfi_h,
                            input logic [3:0] a, input logic [3:0] i);
        logic v;
        v = (h2 >= 0);
        cycle(1'b1, r, v, 2'(v ? h2 : 0), v && h2 == lsu_h, v && h2 == wfi_h, a, i);
        h2 = h1; h1 = m_pick;
    endtask

    // Stall a hart via LSU (woken by hack) or WFI (woken by irq) and time its reissue.
    task automatic stall_test(input string nm, input int hs, input bit lsu);
        int t, absent, lat;
        logic [3:0] a, i;
        t = -1; absent = 0; lat = -1;
        for (int k = 0; k < 30; k++) begin
            a = (lsu && t >= 0 && k == t + 5) ? 4'(1 << hs) : 4'h0;
            i = (!lsu && t >= 0 && k >= t + 5) ? 4'(1 << hs) : 4'h0;
            if (t < 0 && h2 == hs) t = k;
            rot_step(4'hF, (lsu && t == k) ? hs : -1, (!lsu && t == k) ? hs : -1, a, i);
            if (t >= 0 && k > t && k <= t + 5 && fvld && int'(fhart) == hs) absent++;
            if (t >= 0 && k > t + 5 && lat < 0 && fvld && int'(fhart) == hs) lat = k - (t + 5);
        end
        chk({nm, "_reported"}, int'(t >= 0), 1);
        chk({nm, "_absent"}, absent, 0);
        chk({nm, "_reissue_within_4"}, int'(lat >= 1 && lat <= 4), 1);
    endtask

    always @(negedge sclk) begin
        if (!srst) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                chk("fvld_missing", 0, 1);
                void'(sb_q.pop_front());
            end
            if (fvld) begin
                if (sb_q.size() == 0 || sb_q[0].cyc != cyc) chk("fvld_spurious", 1, 0);
                else chk("fhart", int'(fhart), sb_q.pop_front().hart);
            end
        end
    end

    initial begin
        int got[$];
        int exp_seq[5];
        int n3, nt;
        exp_seq = '{0, 1, 2, 3, 0};
        srst = 1'b1; sena = 1'b0; hrun = 4'h0; qvld = 1'b0; qhart = 2'd0;
        qlsu = 1'b0; qwfi = 1'b0; hack = 4'h0; irq = 4'h0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        chk("init_fvld", int'(fvld), 0);
        chk("init_fhart", int'(fhart), 0);
        chk("init_hidle", int'(hidle), 15);
        chk("init_tout", int'(tout), 0);
        srst = 1'b0;

        // Full rotation with plain reports.
        for (int k = 0; k < 12; k++) begin
            rot_step(4'hF, -1, -1, 4'h0, 4'h0);
            if (fvld && got.size() < 5) got.push_back(int'(fhart));
        end
        for (int k = 0; k < 5; k++) chk("rot_seq", (got.size() > k) ? got[k] : -1, exp_seq[k]);

        stall_test("lsu_h1", 1, 1'b1);
        stall_test("wfi_h2", 2, 1'b0);

        // Report with LSU and completion in the same cycle on the only enabled hart.
        reset_pulse();
        cycle(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 1'b0, 4'h1, 4'h0);
        cycle(1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("same_cycle_ack_fvld", int'(fvld), 1);
        chk("same_cycle_ack_fhart", int'(fhart), 0);

        // Hart 3 parked in WAIT with no completion.
        reset_pulse();
        cycle(1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'h0);
        n3 = 0; nt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
            if (fvld && fhart == 2'd3) n3++;
            if (tout == 4'b1000) nt++;
        end
`ifdef T5_SCHED_WDOG_EN
        chk("wdog_reissue", n3, 1);
        chk("wdog_tout_pulses", nt, 1);
`else
        chk("wait_holds_issue", n3, 0);
        chk("wait_holds_tout", nt, 0);
`endif

        // Asynchronous reset while harts are BUSY or WAIT.
        reset_pulse();
        for (int k = 0; k < 8; k++) rot_step(4'hF, 0, -1, 4'h0, 4'h0);
        reset_pulse();
        cycle(1'b1, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("post_rst_fvld", int'(fvld), 1);
        chk("post_rst_fhart", int'(fhart), 0);

        // Randomized traffic with occasional mid-run resets.
        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 350) reset_pulse();
            cycle(($urandom % 100) < 85,
                  ($urandom % 16 == 0) ? 4'($urandom) : 4'hF,
                  ($urandom % 10) < 6, 2'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0,
                  4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom) & 4'($urandom));
        end
        cycle(1'b0, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge sclk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
